tff_seq_ctrl: RTL and testbench
===============================

Name: tff_seq_ctrl

Overview:
- Sequencer for a bank of T flip-flops used as a bounded up/down counter.
- Computes per-bit toggle enables so the bank steps, loads and wraps under FSM control; the bank itself never computes its own next state.
- Sits between debounced board inputs (KEY/SW) and LED/7-seg display logic.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank; counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level, sampled in IDLE; begins a counting pass.
- stop  input  1  level, sampled in RUN; aborts the pass.
- step_en  input  1  single-cycle step request (pre-debounced).
- dir  input  1  direction: 0 = up, 1 = down; sampled at start.
- mod_val  input  WIDTH  terminal limit; sampled at start.
- count  output  WIDTH  T-bank outputs (q vector).
- t_vec  output  WIDTH  toggle enables driven into the bank this cycle; combinational.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a pass completes.
- wrap  output  1  one-cycle pulse on wrap-around (only with the optional feature).

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, count=0, limit_r=0, dir_r=0, busy=0, done=0, wrap=0. Reset takes effect immediately, including mid-pass.
- Update rule: every count change uses t_vec = count XOR next_count. When holding, t_vec = 0. The bank toggles bit i at the clock edge when t_vec[i]=1.
- States: IDLE=0, RUN=1, DONE=2. busy is registered: busy = (state==RUN).
- IDLE:
  - start=1: limit_r <= mod_val, dir_r <= dir, count <= (dir ? mod_val : 0), go to RUN.
  - stop and step_en are ignored.
- RUN: step_en and stop are evaluated in the same cycle, and stop has priority.
  - stop=1: go to IDLE. count holds, done=0.
  - step_en=1 and count != term: count steps by +1 (up) or -1 (down). term = limit_r for up, 0 for down.
  - step_en=1 and count == term: go to DONE and count holds.
  - start is ignored in RUN.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE. All inputs are ignored in DONE.
- Step count: a pass performs limit_r transitions, so the (limit_r+1)th step ends it.
- mod_val=0: the first step in RUN ends the pass.
- Latency: count changes at the first clock edge where step_en is sampled high. done is asserted the cycle after that edge.
- Arithmetic is modulo 2^WIDTH. Internal wrap cannot occur outside the optional feature, because the terminal check precedes the increment/decrement.

Optional Feature:
- Macro: TFF_SEQ_CONTINUOUS_EN.
- Defined: a step at term reloads the start value (0 for up, limit_r for down), pulses wrap for one cycle and stays in RUN. DONE is unreachable, and only stop exits RUN.
- Undefined: single-pass behaviour as above. wrap is tied to 0.

Decomposition:
- Package tff_seq_pkg holds:
  - state encodings ST_IDLE/ST_RUN/ST_DONE (2 bits);
  - DIR_UP=0 and DIR_DOWN=1.
- Sub-module tff_bank holds WIDTH T flip-flops, each built as a D flip-flop with d = t XOR q.
  - Ports: clk, rst, t[WIDTH-1:0], q[WIDTH-1:0].
  - Async reset to 0.
- The controller holds the FSM, the limit/direction registers and the next-count/t_vec logic.

Test Plan (WIDTH=4):
1. Up count: dir=0, mod_val=3, start, then 4 step pulses. Required: count 0→1→2→3. The 4th step gives done=1 for one cycle, count stays 3 and busy falls.
2. Down count: dir=1, mod_val=9, start. Required: count=9 after start. After 9 steps count=0, and the 10th step gives a done pulse with count still 0.
3. Toggle vector: during the up pass with mod_val=15, step from count=7. Required: t_vec=1111 in the cycle before the edge, and count=8 after it.
4. Stop priority: at count=2, assert stop and step_en in the same cycle. Required: IDLE, count=2, done=0, busy=0.
5. Async reset: count=5 in RUN, pulse rst between clock edges. Required: count=0 and busy=0 immediately, with no clock edge needed.
6. Continuous mode (TFF_SEQ_CONTINUOUS_EN): up, mod_val=2, 4 steps. Required: count 0→1→2→0→1, wrap pulses exactly once, busy stays 1 and done never asserts.

Source files
------------

// File: rtl/tff_seq_pkg.sv
// rtl/tff_seq_pkg.sv - shared state encodings and direction constants for the T-bank sequencer
package tff_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tff_seq_ctrl_if.sv
// rtl/tff_seq_ctrl_if.sv - control and status bundle between board inputs, sequencer and display logic
interface tff_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             step_en;
    logic             dir;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] t_vec;
    logic             busy;
    logic             done;
    logic             wrap;

    modport master (
        output start, stop, step_en, dir, mod_val,
        input  count, t_vec, busy, done, wrap
    );

    modport slave (
        input  start, stop, step_en, dir, mod_val,
        output count, t_vec, busy, done, wrap
    );
endinterface

// File: rtl/tff_bank.sv
// rtl/tff_bank.sv - bank of T flip-flops, each a D flop with d = t ^ q
module tff_bank #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= t ^ q;
        end
    end

endmodule

// File: rtl/tff_seq_ctrl.sv
// rtl/tff_seq_ctrl.sv - FSM driving toggle enables into a T-bank counter; TFF_SEQ_CONTINUOUS_EN enables wrap-around mode
module tff_seq_ctrl
    import tff_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    tff_seq_ctrl_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] limit_r, limit_nxt;
    logic             dir_r, dir_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] t_vec;
`ifdef TFF_SEQ_CONTINUOUS_EN
    logic             wrap_r, wrap_nxt;
`endif

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk (clk),
        .rst (rst),
        .t   (t_vec),
        .q   (count)
    );

    assign term = (dir_r == DIR_DOWN) ? '0 : limit_r;

    always_comb begin
        state_nxt = state;
        limit_nxt = limit_r;
        dir_nxt   = dir_r;
        count_nxt = count;
`ifdef TFF_SEQ_CONTINUOUS_EN
        wrap_nxt  = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    limit_nxt = bus.mod_val;
                    dir_nxt   = bus.dir;
                    count_nxt = (bus.dir == DIR_DOWN) ? bus.mod_val : '0;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // stop wins over a coincident step so an abort never moves the count
                if (bus.stop) begin
                    state_nxt = ST_IDLE;
                end else if (bus.step_en) begin
                    if (count == term) begin
`ifdef TFF_SEQ_CONTINUOUS_EN
                        count_nxt = (dir_r == DIR_DOWN) ? limit_r : '0;
                        wrap_nxt  = 1'b1;
`else
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        count_nxt = (dir_r == DIR_DOWN) ? (count - ONE) : (count + ONE);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The bank only ever sees the difference between the present and desired count
    assign t_vec = count ^ count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            limit_r <= '0;
            dir_r   <= DIR_UP;
`ifdef TFF_SEQ_CONTINUOUS_EN
            wrap_r  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            limit_r <= limit_nxt;
            dir_r   <= dir_nxt;
`ifdef TFF_SEQ_CONTINUOUS_EN
            wrap_r  <= wrap_nxt;
`endif
        end
    end

    assign bus.count = count;
    assign bus.t_vec = t_vec;
    assign bus.busy  = (state == ST_RUN);
    assign bus.done  = (state == ST_DONE);
`ifdef TFF_SEQ_CONTINUOUS_EN
    assign bus.wrap  = wrap_r;
`else
    assign bus.wrap  = 1'b0;
`endif

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// tb/tb_tff_seq_ctrl.sv - table-driven self-checking bench for tff_seq_ctrl
module tb_tff_seq_ctrl;

    typedef struct {
        logic       start;
        logic       stop;
        logic       step_en;
        logic       dir;
        logic [3:0] mod_val;
        logic [3:0] exp_t;
        logic [3:0] exp_count;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_wrap;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    tff_seq_ctrl_if #(.WIDTH(4)) bus ();

    tff_seq_ctrl #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic p, input logic e, input logic d,
                       input logic [3:0] m, input logic [3:0] t, input logic [3:0] c,
                       input logic b, input logic dn, input logic w);
        vec_t v;
        v.start = s; v.stop = p; v.step_en = e; v.dir = d; v.mod_val = m;
        v.exp_t = t; v.exp_count = c; v.exp_busy = b; v.exp_done = dn; v.exp_wrap = w;
        vecs.push_back(v);
    endtask

    // Called just after a falling edge: drive, check t_vec, clock, check state after the edge
    task automatic apply(input vec_t v, input string tag);
        bus.start   = v.start;
        bus.stop    = v.stop;
        bus.step_en = v.step_en;
        bus.dir     = v.dir;
        bus.mod_val = v.mod_val;
        #1;
        chk({tag, " t_vec"}, int'(bus.t_vec), int'(v.exp_t));
        @(negedge clk);
        chk({tag, " count"}, int'(bus.count), int'(v.exp_count));
        chk({tag, " busy"},  int'(bus.busy),  int'(v.exp_busy));
        chk({tag, " done"},  int'(bus.done),  int'(v.exp_done));
        chk({tag, " wrap"},  int'(bus.wrap),  int'(v.exp_wrap));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        bus.start = 0; bus.stop = 0; bus.step_en = 0; bus.dir = 0; bus.mod_val = '0;

`ifndef TFF_SEQ_CONTINUOUS_EN
        // up pass, mod 3
        add(0,0,0,0,4'd0,  4'd0, 4'd0,1'b0,1'b0,1'b0);
        add(1,0,0,0,4'd3,  4'd0, 4'd0,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd1,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd3, 4'd2,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd3,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd0, 4'd3,1'b0,1'b1,1'b0);
        add(0,0,0,0,4'd0,  4'd0, 4'd3,1'b0,1'b0,1'b0);
        // down pass, mod 9; dir input deliberately low after start
        add(1,0,0,1,4'd9,  4'd10,4'd9,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd8,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd15,4'd7,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd6,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd3, 4'd5,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd4,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd7, 4'd3,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd2,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd3, 4'd1,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd0,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd0, 4'd0,1'b0,1'b1,1'b0);
        add(1,0,0,0,4'd5,  4'd0, 4'd0,1'b0,1'b0,1'b0);   // start ignored in DONE
        // up pass, mod 15, through the 7->8 all-bits toggle
        add(1,0,0,0,4'd15, 4'd0, 4'd0,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd1,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd3, 4'd2,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd3,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd7, 4'd4,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd5,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd3, 4'd6,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd7,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd15,4'd8,1'b1,1'b0,1'b0);
        add(1,0,0,0,4'd3,  4'd0, 4'd8,1'b1,1'b0,1'b0);   // start ignored in RUN
        add(0,1,0,0,4'd0,  4'd0, 4'd8,1'b0,1'b0,1'b0);
        // stop priority at count 2
        add(1,0,0,0,4'd5,  4'd8, 4'd0,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd1, 4'd1,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd3, 4'd2,1'b1,1'b0,1'b0);
        add(0,1,1,0,4'd0,  4'd0, 4'd2,1'b0,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd0, 4'd2,1'b0,1'b0,1'b0);   // step ignored in IDLE
        // mod_val = 0: first step ends the pass
        add(1,0,0,0,4'd0,  4'd2, 4'd0,1'b1,1'b0,1'b0);
        add(0,0,1,0,4'd0,  4'd0, 4'd0,1'b0,1'b1,1'b0);
        add(0,0,0,0,4'd0,  4'd0, 4'd0,1'b0,1'b0,1'b0);
`endif

        repeat (2) @(negedge clk);
        #2;
        chk("reset count", int'(bus.count), 0);
        chk("reset busy",  int'(bus.busy),  0);
        chk("reset done",  int'(bus.done),  0);
        chk("reset wrap",  int'(bus.wrap),  0);
        chk("reset t_vec", int'(bus.t_vec), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // asynchronous reset mid-pass at count 5
        add(1,0,0,0,4'd15, 4'd0, 4'd0,1'b1,1'b0,1'b0);
        v = vecs[vecs.size()-1];
        apply(v, "ar start");
        for (int i = 1; i <= 5; i++) begin
            v.start = 0; v.step_en = 1; v.mod_val = '0;
            v.exp_count = 4'(i);
            v.exp_t = 4'(i) ^ 4'(i - 1);
            apply(v, $sformatf("ar step%0d", i));
        end
        bus.step_en = 0;
        #2 rst = 1'b1;
        #1;
        chk("async rst count", int'(bus.count), 0);
        chk("async rst busy",  int'(bus.busy),  0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post rst busy", int'(bus.busy), 0);

`ifdef TFF_SEQ_CONTINUOUS_EN
        begin
            vec_t c;
            c.stop = 0; c.dir = 0; c.exp_done = 0;
            c.start = 1; c.step_en = 0; c.mod_val = 4'd2;
            c.exp_t = 4'd0; c.exp_count = 4'd0; c.exp_busy = 1; c.exp_wrap = 0;
            apply(c, "cont start");
            c.start = 0; c.step_en = 1; c.mod_val = '0;
            c.exp_t = 4'd1; c.exp_count = 4'd1; c.exp_wrap = 0; apply(c, "cont s1");
            c.exp_t = 4'd3; c.exp_count = 4'd2; c.exp_wrap = 0; apply(c, "cont s2");
            c.exp_t = 4'd2; c.exp_count = 4'd0; c.exp_wrap = 1; apply(c, "cont s3");
            c.exp_t = 4'd1; c.exp_count = 4'd1; c.exp_wrap = 0; apply(c, "cont s4");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
